// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the simulation run-control sequencer.
// State encoding plus debug-port source selects.
package sim_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_HOLD,
    ST_RUN,
    ST_DRAIN,
    ST_DUMP_REG,
    ST_DUMP_MEM,
    ST_DONE
  } run_state_e;

  localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_000C;

  localparam logic DBG_SEL_REG = 1'b0;
  localparam logic DBG_SEL_MEM = 1'b1;

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Snapshot stream port: one beat per valid/ready handshake.
// Master drives the beat, slave answers with ready.
interface sim_run_ctrl_if #(
  parameter int AW = 5
) ();
  logic          valid;
  logic          ready;
  logic          sel;
  logic [AW-1:0] addr;
  logic [31:0]   data;

  modport master (
    output valid, sel, addr, data,
    input  ready
  );

  modport slave (
    input  valid, sel, addr, data,
    output ready
  );
endinterface

// File: rtl/sim_run_ctrl_halt_detect.sv
// Halt detector: halt instruction fetch or a PC that sits still
// for IDLE_PC_LIMIT consecutive samples (first sample included).
module sim_run_ctrl_halt_detect #(
  parameter int          PC_W          = 32,
  parameter int          IDLE_PC_LIMIT = 8,
  parameter logic [31:0] HALT_INSTR    = 32'h0000_000C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_en,
  input  logic [PC_W-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic            o_halt
);

  localparam int LW = $clog2(IDLE_PC_LIMIT + 1);
  localparam logic [LW-1:0] LIM = LW'(IDLE_PC_LIMIT);

  logic [PC_W-1:0] r_prev_pc;
  logic            r_have_prev;
  logic [LW-1:0]   r_len;

  logic            w_same;
  logic [LW-1:0]   w_len_nxt;

  assign w_same = r_have_prev && (i_pc == r_prev_pc);

  always_comb begin
    w_len_nxt = LW'(1);
    if (w_same) begin
      w_len_nxt = (r_len >= LIM) ? r_len : r_len + 1'b1;
    end
  end

  assign o_halt = i_en &&
                  ((i_instr == HALT_INSTR) || (w_len_nxt >= LIM));

  always_ff @(posedge clk) begin
    if (!reset || !i_en) begin
      r_prev_pc   <= '0;
      r_have_prev <= 1'b0;
      r_len       <= '0;
    end else begin
      r_prev_pc   <= i_pc;
      r_have_prev <= 1'b1;
      r_len       <= w_len_nxt;
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run-control sequencer: reset hold, run, halt/timeout, drain,
// freeze, then stream a register-file and memory snapshot.
module sim_run_ctrl
  import sim_run_ctrl_pkg::*;
#(
  parameter int          PC_W          = 32,
  parameter int          CYC_W         = 32,
  parameter int          RESET_CYCLES  = 2,
  parameter int          MAX_CYCLES    = 1700,
  parameter int          DRAIN_CYCLES  = 4,
  parameter int          IDLE_PC_LIMIT = 8,
  parameter logic [31:0] HALT_INSTR    = HALT_INSTR_DEF,
  parameter int          NUM_REGS      = 32,
  parameter int          NUM_MEM       = 8,
  parameter int          DBG_AW        = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              core_rst,
  output logic              core_run,
  input  logic [PC_W-1:0]   pc,
  input  logic [31:0]       instr,
  output logic              dbg_sel,
  output logic [DBG_AW-1:0] dbg_addr,
  input  logic [31:0]       dbg_data,
  sim_run_ctrl_if.master    dump,
  output logic [CYC_W-1:0]  cycle_count,
  output logic              halted,
  output logic              timeout,
  output logic              done
);

  run_state_e        r_state;
  logic [31:0]       r_cnt;
  logic [DBG_AW-1:0] r_idx;
  logic [CYC_W-1:0]  r_cyc;
  logic              r_halted;
  logic              r_timeout;

  run_state_e        w_state_nxt;
  logic [31:0]       w_cnt_nxt;
  logic [DBG_AW-1:0] w_idx_nxt;
  logic [CYC_W-1:0]  w_cyc_nxt;
  logic              w_halted_nxt;
  logic              w_timeout_nxt;
  logic [CYC_W-1:0]  w_cyc_inc;
  logic              w_tmo;
  logic              w_halt;
  logic              w_hd_en;
  logic              w_valid;
  logic              w_fire;

  sim_run_ctrl_halt_detect #(
    .PC_W          (PC_W),
    .IDLE_PC_LIMIT (IDLE_PC_LIMIT),
    .HALT_INSTR    (HALT_INSTR)
  ) u_halt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_hd_en),
    .i_pc    (pc),
    .i_instr (instr),
    .o_halt  (w_halt)
  );

  // Saturating: a long run pins at all-ones instead of wrapping.
  assign w_cyc_inc = (&r_cyc) ? r_cyc : r_cyc + 1'b1;
  assign w_tmo     = w_cyc_inc >= CYC_W'(MAX_CYCLES - 1);
  assign w_fire    = w_valid && dump.ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_cyc_nxt     = r_cyc;
    w_halted_nxt  = r_halted;
    w_timeout_nxt = r_timeout;
    core_rst      = 1'b0;
    core_run      = 1'b0;
    dbg_sel       = DBG_SEL_REG;
    w_valid       = 1'b0;
    w_hd_en       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        core_rst = (r_state == ST_IDLE);
        if (start) begin
          w_state_nxt   = ST_RESET_HOLD;
          w_cnt_nxt     = '0;
          w_cyc_nxt     = '0;
          w_halted_nxt  = 1'b0;
          w_timeout_nxt = 1'b0;
          w_idx_nxt     = '0;
        end
      end
      ST_RESET_HOLD: begin
        core_rst = 1'b1;
        if (r_cnt == 32'(RESET_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_RUN: begin
        core_run  = 1'b1;
        w_hd_en   = 1'b1;
        w_cyc_nxt = w_cyc_inc;
        // Halt has priority over a coincident timeout.
        if (w_halt) begin
          w_halted_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_idx_nxt    = '0;
          w_state_nxt  = (DRAIN_CYCLES == 0) ? ST_DUMP_REG
                                             : ST_DRAIN;
        end else if (w_tmo) begin
          w_timeout_nxt = 1'b1;
          w_idx_nxt     = '0;
          w_state_nxt   = ST_DUMP_REG;
        end
      end
      ST_DRAIN: begin
        core_run  = 1'b1;
        w_cyc_nxt = w_cyc_inc;
        if (r_cnt == 32'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = ST_DUMP_REG;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_DUMP_REG: begin
        w_valid = 1'b1;
        if (w_fire) begin
          if (r_idx == DBG_AW'(NUM_REGS - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = (NUM_MEM == 0) ? ST_DONE : ST_DUMP_MEM;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ST_DUMP_MEM: begin
        w_valid = 1'b1;
        dbg_sel = DBG_SEL_MEM;
        if (w_fire) begin
          if (r_idx == DBG_AW'(NUM_MEM - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_cyc     <= '0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_cyc     <= w_cyc_nxt;
      r_halted  <= w_halted_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign dbg_addr    = r_idx;
  assign dump.valid  = w_valid;
  assign dump.sel    = dbg_sel;
  assign dump.addr   = r_idx;
  assign dump.data   = dbg_data;
  assign cycle_count = r_cyc;
  assign halted      = r_halted;
  assign timeout     = r_timeout;
  assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: reset, halt, stuck PC,
// timeout, halt/timeout tie, snapshot streaming, mid-run abort.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        core_rst;
  logic        core_run;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        dbg_sel;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] cycle_count;
  logic        halted;
  logic        timeout;
  logic        done;

  int total = 0;
  int bad   = 0;

  sim_run_ctrl_if #(.AW(5)) u_dump ();

  sim_run_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .core_rst    (core_rst),
    .core_run    (core_run),
    .pc          (pc),
    .instr       (instr),
    .dbg_sel     (dbg_sel),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dump        (u_dump),
    .cycle_count (cycle_count),
    .halted      (halted),
    .timeout     (timeout),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl(input logic s, input logic [4:0] a);
    mdl = s ? (32'hD000_0000 + 32'(a) * 32'd7)
            : (32'h1000_0000 + 32'(a) * 32'd3);
  endfunction

  assign dbg_data = mdl(dbg_sel, dbg_addr);

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of run cycle 0.
  task automatic launch();
    start = 1'b1;
    pc    = '0;
    instr = '0;
    @(negedge clk);
    start = 1'b0;
    chk("hold1_rst", core_rst, 1);
    chk("hold1_run", core_run, 0);
    chk("clr_cyc", cycle_count, 0);
    chk("clr_flags", {halted, timeout, done}, 0);
    @(negedge clk);
    chk("hold2_rst", core_rst, 1);
    chk("hold2_run", core_run, 0);
    @(negedge clk);
    chk("run_rst", core_rst, 0);
    chk("run_en", core_run, 1);
    chk("run_cyc0", cycle_count, 0);
  endtask

  task automatic run_core(input int halt_at, input int stuck_at,
                          output int n, output int hit);
    n   = 0;
    hit = -1;
    while (core_run && n < 3000) begin
      pc    = (stuck_at >= 0 && n >= stuck_at) ? 32'h40 : 32'(n * 4);
      instr = (n == halt_at) ? 32'h0000_000C : 32'h0000_0020;
      start = (n == 5);
      @(negedge clk);
      if (halted && hit < 0) hit = n;
      n++;
    end
    start = 1'b0;
    if (n >= 3000) chk("run_bound", 1, 0);
  endtask

  task automatic dump_all(input bit rnd);
    int stall;
    bit rdy;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < ((s == 0) ? 32 : 8); a++) begin
        stall = 0;
        rdy   = 1'b0;
        while (!rdy) begin
          chk($sformatf("beat%0d_%0d", s, a),
              {u_dump.valid, u_dump.sel, u_dump.addr, u_dump.data},
              {1'b1, s[0], a[4:0], mdl(s[0], a[4:0])});
          chk("dbg_sel", dbg_sel, s[0]);
          rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (stall > 20) rdy = 1'b1;
          u_dump.ready = rdy;
          @(negedge clk);
          stall++;
        end
      end
    end
    u_dump.ready = 1'b0;
    chk("done_set", done, 1);
    chk("done_valid", u_dump.valid, 0);
    chk("done_run", core_run, 0);
  endtask

  int n, hit;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    pc    = '0;
    instr = '0;
    u_dump.ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_run", core_run, 0);
    chk("rst_cyc", cycle_count, 0);
    chk("rst_flags", {halted, timeout, done}, 0);
    chk("rst_valid", u_dump.valid, 0);
    chk("rst_dbg", {dbg_sel, dbg_addr}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_rst", core_rst, 1);

    // Halt instruction at run cycle 100, then four drain cycles.
    launch();
    run_core(100, -1, n, hit);
    chk("halt_n", n, 105);
    chk("halt_cyc", cycle_count, 105);
    chk("halt_hit", hit, 100);
    chk("halt_flags", {halted, timeout}, 2'b10);
    chk("halt_dump0", {u_dump.valid, dbg_sel, dbg_addr}, {1'b1, 6'd0});
    chk("halt_frz", {core_run, core_rst}, 0);
    dump_all(1'b0);
    repeat (3) @(negedge clk);
    chk("done_hold", done, 1);
    chk("done_cyc", cycle_count, 105);
    chk("done_halted", halted, 1);

    // PC stuck at 0x40 from run cycle 20: eighth sample is cycle 27.
    launch();
    run_core(-1, 20, n, hit);
    chk("stuck_hit", hit, 27);
    chk("stuck_cyc", cycle_count, 32);
    chk("stuck_flags", {halted, timeout}, 2'b10);
    dump_all(1'b1);

    // No halt: budget runs out after 1699 run cycles.
    launch();
    run_core(-1, -1, n, hit);
    chk("tmo_n", n, 1699);
    chk("tmo_cyc", cycle_count, 1699);
    chk("tmo_flags", {halted, timeout}, 2'b01);
    chk("tmo_dump0", {u_dump.valid, dbg_sel, dbg_addr}, {1'b1, 6'd0});
    dump_all(1'b0);

    // Halt on the same cycle the budget expires: halt wins.
    launch();
    run_core(1698, -1, n, hit);
    chk("tie_cyc", cycle_count, 1703);
    chk("tie_flags", {halted, timeout}, 2'b10);
    dump_all(1'b1);

    // Reset at run cycle 50 aborts the run.
    launch();
    for (int i = 0; i < 50; i++) begin
      pc    = 32'(i * 4);
      instr = 32'h0000_0020;
      @(negedge clk);
    end
    chk("abort_pre_run", core_run, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_rst", core_rst, 1);
    chk("abort_run", core_run, 0);
    chk("abort_cyc", cycle_count, 0);
    chk("abort_valid", u_dump.valid, 0);
    chk("abort_flags", {halted, timeout, done}, 0);
    repeat (3) @(negedge clk);
    chk("abort_idle", {core_rst, core_run}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
